// File: rtl/fdiv_cascade.sv
// Cascaded clock-enable generator: a prescaler stage followed by identical decade
// stages, each producing a one-cycle tick and a near-50% square wave on one clock.
module fdiv_cascade #(
  parameter int PRE_DIV = 10000,
  parameter int DIV     = 10,
  parameter int STAGES  = 4,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [SEL_W-1:0]  sel,
  output logic [STAGES-1:0] tick,
  output logic [STAGES-1:0] sq,
  output logic              sel_tick,
  output logic              sel_sq
);

  localparam int PW   = $clog2(PRE_DIV);
  localparam int DW   = $clog2(DIV);
  localparam int NSEL = 2 ** SEL_W;

  if (PRE_DIV < 2) begin : g_bad_pre_div
    $error("fdiv_cascade: PRE_DIV must be at least 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("fdiv_cascade: DIV must be at least 2");
  end
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("fdiv_cascade: STAGES must be in 1..16");
  end
  if (NSEL < STAGES) begin : g_bad_sel_w
    $error("fdiv_cascade: SEL_W too narrow to address every stage");
  end

  logic [STAGES-1:0] at_max;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] sq_nxt;
  logic [STAGES-1:0] sq_hold;
  logic [NSEL-1:0]   tick_ext;
  logic [NSEL-1:0]   sq_ext;
  logic              sel_in;

  // Carry k fires when every stage 0..k sits on its terminal count; built from
  // the per-stage terminal flags so the chain has no combinational self-loop.
  always_comb begin
    logic c;
    c = en;
    for (int k = 0; k < STAGES; k++) begin
      c        = c & at_max[k];
      carry[k] = c;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_pre
      logic [PW-1:0] cnt;
      logic [PW-1:0] cnt_nxt;

      assign at_max[0] = (cnt == PW'(PRE_DIV - 1));
      assign cnt_nxt   = !en ? cnt : (at_max[0] ? '0 : cnt + PW'(1));
      assign sq_nxt[0] = (cnt_nxt < PW'(PRE_DIV / 2));

      always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else               cnt <= cnt_nxt;
      end
    end else begin : g_dec
      logic [DW-1:0] cnt;
      logic [DW-1:0] cnt_nxt;

      assign at_max[k] = (cnt == DW'(DIV - 1));
      assign cnt_nxt   = !carry[k-1] ? cnt : (at_max[k] ? '0 : cnt + DW'(1));
      assign sq_nxt[k] = (cnt_nxt < DW'(DIV / 2));

      always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else               cnt <= cnt_nxt;
      end
    end
  end

  // Zero-extending to the full select range makes out-of-range sel read 0.
  assign sq_hold  = en ? sq_nxt : sq;
  assign tick_ext = NSEL'(carry);
  assign sq_ext   = NSEL'(sq_hold);
  assign sel_in   = (int'(sel) < STAGES);

  // Output registers: sel_* sample the next-state vectors so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tick     <= '0;
      sq       <= '1;
      sel_tick <= 1'b0;
      sel_sq   <= sel_in;
    end else begin
      tick     <= carry;
      sq       <= sq_hold;
      sel_tick <= tick_ext[sel];
      sel_sq   <= sq_ext[sel];
    end
  end

endmodule

// File: tb/tb_fdiv_cascade.sv
// Scoreboard bench for fdiv_cascade (PRE_DIV=3, DIV=3, STAGES=4, SEL_W=3): an
// arithmetic model plus hand-computed spot values feed a queue drained by a monitor.
module tb_fdiv_cascade;

  localparam int P  = 3;
  localparam int D  = 3;
  localparam int S  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [S-1:0]  tick;
  logic [S-1:0]  sq;
  logic          sel_tick;
  logic          sel_sq;

  always #5 clk = ~clk;

  fdiv_cascade #(.PRE_DIV(P), .DIV(D), .STAGES(S), .SEL_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .sel      (sel),
    .tick     (tick),
    .sq       (sq),
    .sel_tick (sel_tick),
    .sel_sq   (sel_sq)
  );

  typedef struct {
    logic [S-1:0] tick;
    logic [S-1:0] sq;
    logic         st;
    logic         ss;
    bit           hv;
    logic [S-1:0] htick;
    logic [S-1:0] hsq;
    logic         hst;
    logic         hss;
    int           ph;
    int           cyc;
  } item_t;

  typedef struct {
    int           ph;
    int           cyc;
    logic [S-1:0] tick;
    logic [S-1:0] sq;
    logic         st;
    logic         ss;
  } hand_t;

  item_t q[$];
  hand_t htab[15];
  int    checks = 0;
  int    errors = 0;
  int    hand_hits = 0;

  longint       n;
  logic [S-1:0] m_sq;
  int           ph;
  int           pc;

  function automatic longint per(int k);
    longint r;
    r = P;
    for (int i = 0; i < k; i++) r = r * D;
    return r;
  endfunction

  function automatic logic [S-1:0] sq_of(longint cnt);
    logic [S-1:0] r;
    r[0] = (cnt % P) < (P / 2);
    for (int k = 1; k < S; k++) r[k] = ((cnt / per(k - 1)) % D) < (D / 2);
    return r;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (phase %0d cycle %0d): got %0h, expected %0h", nm, ph, cyc, act, exp);
    end
  endtask

  // Drive one edge's inputs, advance the model, queue the expected post-edge outputs.
  task automatic step(input logic r, input logic c, input logic e, input logic [SW-1:0] s);
    item_t it;
    @(negedge clk);
    rst_n = r;
    clr   = c;
    en    = e;
    sel   = s;
    if (!r || c) begin
      n       = 0;
      m_sq    = '1;
      it.tick = '0;
    end else if (e) begin
      for (int k = 0; k < S; k++) it.tick[k] = ((n + 1) % per(k)) == 0;
      n    = n + 1;
      m_sq = sq_of(n);
    end else begin
      it.tick = '0;
    end
    it.sq = m_sq;
    if (!r || c) begin
      it.st = 1'b0;
      it.ss = (int'(s) < S);
    end else begin
      it.st = (int'(s) < S) ? it.tick[s[1:0]] : 1'b0;
      it.ss = (int'(s) < S) ? m_sq[s[1:0]] : 1'b0;
    end
    it.ph    = ph;
    it.cyc   = pc + 1;
    it.hv    = 1'b0;
    it.htick = '0;
    it.hsq   = '0;
    it.hst   = 1'b0;
    it.hss   = 1'b0;
    foreach (htab[i]) begin
      if (htab[i].ph == ph && htab[i].cyc == pc + 1) begin
        it.hv    = 1'b1;
        it.htick = htab[i].tick;
        it.hsq   = htab[i].sq;
        it.hst   = htab[i].st;
        it.hss   = htab[i].ss;
      end
    end
    q.push_back(it);
    pc++;
  endtask

  task automatic start_phase(input int p, input logic [SW-1:0] s);
    ph = p;
    pc = -2;
    step(1'b0, 1'b0, 1'b0, s);
    step(1'b0, 1'b0, 1'b0, s);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued item per edge.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      chk("tick", it.cyc, 32'(tick), 32'(it.tick));
      chk("sq", it.cyc, 32'(sq), 32'(it.sq));
      chk("sel_tick", it.cyc, 32'(sel_tick), 32'(it.st));
      chk("sel_sq", it.cyc, 32'(sel_sq), 32'(it.ss));
      if (it.hv) begin
        hand_hits++;
        chk("hand_tick", it.cyc, 32'(tick), 32'(it.htick));
        chk("hand_sq", it.cyc, 32'(sq), 32'(it.hsq));
        chk("hand_sel_tick", it.cyc, 32'(sel_tick), 32'(it.hst));
        chk("hand_sel_sq", it.cyc, 32'(sel_sq), 32'(it.hss));
      end
    end
  end

  initial begin
    // phase, cycle, tick, sq, sel_tick, sel_sq
    htab[0]  = '{1,  0, 4'b0000, 4'b1111, 1'b0, 1'b1};
    htab[1]  = '{1,  3, 4'b0001, 4'b1101, 1'b0, 1'b1};
    htab[2]  = '{1,  4, 4'b0000, 4'b1100, 1'b0, 1'b1};
    htab[3]  = '{1,  9, 4'b0011, 4'b1011, 1'b0, 1'b1};
    htab[4]  = '{1, 27, 4'b0111, 4'b0111, 1'b0, 1'b0};
    htab[5]  = '{1, 81, 4'b1111, 4'b1111, 1'b1, 1'b1};
    htab[6]  = '{2,  6, 4'b0000, 4'b1100, 1'b0, 1'b0};
    htab[7]  = '{2,  9, 4'b0000, 4'b1100, 1'b0, 1'b0};
    htab[8]  = '{2, 11, 4'b0001, 4'b1101, 1'b1, 1'b1};
    htab[9]  = '{2, 14, 4'b0011, 4'b1011, 1'b1, 1'b1};
    htab[10] = '{3,  8, 4'b0000, 4'b1111, 1'b0, 1'b0};
    htab[11] = '{3, 11, 4'b0001, 4'b1101, 1'b0, 1'b0};
    htab[12] = '{3, 14, 4'b0000, 4'b1111, 1'b0, 1'b0};
    htab[13] = '{3, 21, 4'b0000, 4'b1111, 1'b0, 1'b0};
    htab[14] = '{3, 24, 4'b0001, 4'b1101, 1'b0, 1'b0};
    n    = 0;
    m_sq = '1;

    // Free run with sel on the slowest stage.
    start_phase(1, 3'd3);
    for (int c = 0; c < 95; c++) step(1'b1, 1'b0, 1'b1, 3'd3);

    // Pause for 5 cycles starting at cycle 4.
    start_phase(2, 3'd0);
    for (int c = 0; c < 21; c++) step(1'b1, 1'b0, !(c >= 4 && c <= 8), 3'd0);

    // clr at 7 and on a tick-due edge at 13, rst_n low at 20, sel out of range.
    start_phase(3, 3'd5);
    for (int c = 0; c < 31; c++) step(!(c == 20), (c == 7 || c == 13), 1'b1, 3'd5);

    // sel sweep across all codes with occasional pauses.
    start_phase(4, 3'd0);
    for (int c = 0; c < 240; c++)
      step(1'b1, 1'b0, (c % 17) != 5, SW'((c / 3) % 8));

    begin
      int waited;
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      #2;
      chk("queue_drained", 0, 32'(q.size()), 32'd0);
    end
    chk("hand_hits", 0, 32'(hand_hits), 32'd15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdiv_cascade.md
# fdiv_cascade

Parametrised cascaded clock-enable generator for the frequency meter: one prescaler stage plus (STAGES-1) identical decade stages, all clocked by the single system clock. Each stage emits a one-cycle tick enable and a near-50% square wave, so downstream gate and display logic needs no derived clocks. Adds pause, synchronous restart and a runtime-selectable gate output.

## Interface
- PRE_DIV, default 10000: divide ratio of stage 0 (clk cycles per tick[0]); must be ≥ 2.
- DIV, default 10: divide ratio of every stage k ≥ 1 (tick[k-1] pulses per tick[k]); must be ≥ 2.
- STAGES, default 4: number of stages (1..16); default outputs 1 kHz/100 Hz/10 Hz/1 Hz from a 10 MHz clock.
- SEL_W, default 2: width of sel; must satisfy 2^SEL_W ≥ STAGES.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  count enable; low freezes every counter and output register.
- clr  in  1  synchronous restart: all counters and outputs to reset values; overrides en.
- sel  in  SEL_W  stage index routed to sel_tick/sel_sq.
- tick  out  STAGES  one-cycle enable pulse per stage period.
- sq  out  STAGES  square wave per stage.
- sel_tick  out  1  tick[sel], registered.
- sel_sq  out  1  sq[sel], registered.

## Operation
- Counters: cnt0 width $clog2(PRE_DIV), cntk width $clog2(DIV); all reset to 0.
- Internal carries (combinational): c0 = en & (cnt0 == PRE_DIV-1); ck = c(k-1) & (cntk == DIV-1).
- Stage 0 increments on en, wraps PRE_DIV-1 → 0. Stage k increments when c(k-1) is high, wraps DIV-1 → 0.
- tick[k] register <= ck each cycle; thus all ticks that coincide (e.g. tick[3] with tick[0..2]) appear in the same cycle.
- sq[k] register <= 1 when stage k's next counter value < ratio/2 (integer division), else 0. Odd ratios give low-heavy duty (e.g. ratio 3: high 1/3).
- sel_tick/sel_sq registered from next-state tick[sel]/sq[sel] (aligned with tick/sq, no extra cycle). sel ≥ STAGES forces both to 0.
- Priority per cycle: rst_n low > clr high > en.
- en low: counters hold; tick registers load 0 (no pulse while paused); sq holds.
- Illegal parameters (PRE_DIV < 2, DIV < 2, STAGES outside 1..16, 2^SEL_W < STAGES) must fail elaboration.

## Timing
- Reset/clr values: all counters 0; tick = 0; sel_tick = 0; sq[k] = 1 and sel_sq = 1 only for sel < STAGES (counter value 0 < ratio/2); otherwise 0.
- With en held high from the first cycle after reset release (cycle 0 = first edge with rst_n high): tick[0] first high at cycle PRE_DIV, then every PRE_DIV cycles.
- tick[k] period PRE_DIV·DIV^k cycles, first pulse at cycle PRE_DIV·DIV^k; width exactly 1 cycle.
- sq[k] period equals tick[k] period; sq[k] falls/rises in the same cycle as counter transitions, rising edge coincident with tick[k].
- Latency from en deassert to frozen state: 1 cycle; resuming continues from held counts, no lost or extra tick.
- clr mid-period: counts discarded, next tick[0] PRE_DIV cycles after clr release; a tick due in the clr cycle is suppressed.
- sel change: sel_tick/sel_sq reflect new stage on the next edge; glitch-free (registered).

## Test plan
- PRE_DIV=3, DIV=3, STAGES=4, en=1 after reset: tick[0] at cycles 3,6,9…; tick[1] at 9,18; tick[2] at 27; tick[3] at 81 coincident with tick[0..2]; each one cycle wide.
- Same config, check sq: sq[0] pattern 1,0,0 repeating (high 1 of 3); sq[3] high 27 cycles, low 54, period 81.
- en low for 5 cycles at cycle 4 (cnt0=1): no ticks during pause; next tick[0] at cycle 11, tick[1] at cycle 14.
- clr pulsed at cycle 7: outputs return to reset values at cycle 8; next tick[0] at cycle 11; rst_n low mid-run behaves identically.
- sel swept 0..3 then sel=3'b... out-of-range (STAGES=3, SEL_W=2, sel=3): sel_tick/sel_sq match tick[sel]/sq[sel] cycle-exactly; out-of-range gives constant 0.
- Default parameters (10000/10/4): tick[3] exactly once per 10,000,000 cycles; counters never exceed PRE_DIV-1/DIV-1.
